parking_occupancy_ctrl: RTL and testbench
=========================================

PARKING_OCCUPANCY_CTRL -- requirements
Module: parking_occupancy_ctrl

Interface
REQ-001 Parameter CAPACITY, default 7: maximum number of cars; legal range 1..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 3: width of the count output.
REQ-003 Parameter BLINK_TICKS, default 6000000: clk cycles per half-period of led_full blinking (0.5 s at 12 MHz); minimum 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 s  input  1  entry event from the direction FSM, synchronous to clk; a level held high counts once.
REQ-007 r  input  1  exit event from the direction FSM, synchronous to clk; a level held high counts once.
REQ-008 err_clr  input  1  synchronous clear of both sticky error flags.
REQ-009 count  output  CNT_W  current occupancy, registered.
REQ-010 empty  output  1  high when count == 0, registered.
REQ-011 full  output  1  high when count == CAPACITY, registered.
REQ-012 err_over  output  1  sticky: an entry arrived while full.
REQ-013 err_under  output  1  sticky: an exit arrived while empty.
REQ-014 led_full  output  1  blinking full indicator.

Function
REQ-015 The block SHALL register s and r once and detect a rise as the current sample high with the previous sample low; only rises are events.
REQ-016 On the clk edge that first samples an event, count, empty, full and the error flags SHALL update (1-cycle latency, visible after that edge).
REQ-017 Entry rise only, count < CAPACITY: count +1.
REQ-018 Entry rise only, count == CAPACITY: count holds; err_over set to 1.
REQ-019 Exit rise only, count > 0: count -1.
REQ-020 Exit rise only, count == 0: count holds; err_under set to 1.
REQ-021 Entry and exit rises in the same cycle: count unchanged; no error flag set, including at 0 and at CAPACITY.
REQ-022 count SHALL never exceed CAPACITY and never wrap below 0.
REQ-023 Occupancy state machine, states EMPTY, AVAIL, FULL: EMPTY when count==0, FULL when count==CAPACITY, AVAIL otherwise; transitions follow each count update in the same edge. With CAPACITY==1, AVAIL is unreachable.
REQ-024 err_clr high SHALL clear both error flags on that edge; a new error event in the same cycle takes priority and leaves its flag set.
REQ-025 led_full SHALL be 0 outside FULL.
REQ-026 On entry to FULL, led_full SHALL go 1 on the same edge and the blink timer SHALL restart at 0.
REQ-027 While in FULL, led_full SHALL toggle after every BLINK_TICKS clk cycles.
REQ-028 On leaving FULL, led_full SHALL go 0 and the timer SHALL clear on the same edge.

Reset
REQ-029 While rst_n is low, count=0, empty=1, full=0, err_over=0, err_under=0, led_full=0, state=EMPTY, blink timer=0, and both edge-detect history registers =1.
REQ-030 After release, an s or r level already high at release SHALL NOT count as an event, because the history registers reset to 1.
REQ-031 Reset asserted mid-operation SHALL discard the pending event and the blink phase immediately, without waiting for a clock edge.

Structure
REQ-032 The shared package parking_pkg SHALL hold the occupancy state enum (EMPTY, AVAIL, FULL) and the default CAPACITY and BLINK_TICKS constants.
REQ-033 The rise detector SHALL be a sub-module, rise_detect (clk, rst_n, in, rise), instantiated once for s and once for r.
REQ-034 The blink timer width SHALL be $clog2(BLINK_TICKS).

Verification (CAPACITY=7, CNT_W=3, BLINK_TICKS=4)
REQ-035 Reset, then 3 single-cycle s pulses -> count 0,1,2,3, each one cycle after its pulse; empty falls after the first pulse.
REQ-036 s held high 10 cycles -> count +1 only; and s high through rst_n release -> count stays 0.
REQ-037 Fill to 7, then one more s pulse -> count 7, full=1, err_over=1; then err_clr for 1 cycle -> err_over=0 and count still 7.
REQ-038 At count 7, led_full is observed -> 1 for 4 cycles, 0 for 4 cycles, repeating; then an r pulse -> count 6, full=0, led_full=0 on the same edge.
REQ-039 At count 0, an r pulse -> err_under=1, count 0; simultaneous s+r rises at count 0 and at count 7 -> count unchanged, no new error flag.
REQ-040 Mid-sequence (count 5, led_full high) rst_n pulsed low asynchronously -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared occupancy state type and default sizing constants
package parking_pkg;
   typedef enum logic [1:0] {EMPTY, AVAIL, FULL} occ_state_t;
   localparam int DEF_CAPACITY    = 7;
   localparam int DEF_BLINK_TICKS = 6000000;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse when a synchronous level goes from low to high
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);
   logic hist;
   // history resets high so a level already asserted at reset release is not an event
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hist <= 1'b1;
      else hist <= in;
   assign rise = in & ~hist;
endmodule

// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl: car occupancy counter with sticky error flags and blinking full indicator
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY    = DEF_CAPACITY,
   parameter int CNT_W       = 3,
   parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s,
   input  logic             r,
   input  logic             err_clr,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             err_over,
   output logic             err_under,
   output logic             led_full
);
   localparam int TW = $clog2(BLINK_TICKS);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
   localparam logic [TW-1:0] TMAX = TW'(BLINK_TICKS - 1);
   occ_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [TW-1:0] tmr;
   logic s_rise, r_rise, ent, ext, over_evt, under_evt, led;
   rise_detect u_s (.clk(clk), .rst_n(rst_n), .in(s), .rise(s_rise));
   rise_detect u_r (.clk(clk), .rst_n(rst_n), .in(r), .rise(r_rise));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= EMPTY;
         cnt       <= '0;
         err_over  <= 1'b0;
         err_under <= 1'b0;
         tmr       <= '0;
         led       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         err_over  <= over_evt | (err_over & ~err_clr);
         err_under <= under_evt | (err_under & ~err_clr);
         tmr       <= (state_nxt == FULL && state == FULL) ? ((tmr == TMAX) ? '0 : tmr + TW'(1)) : '0;
         led       <= (state_nxt != FULL) ? 1'b0 : (state != FULL) ? 1'b1 : (tmr == TMAX) ? ~led : led;
      end
   // simultaneous entry and exit cancel out, so neither can raise an error
   always_comb begin
      ent       = s_rise & ~r_rise;
      ext       = r_rise & ~s_rise;
      over_evt  = ent && cnt == CAP;
      under_evt = ext && cnt == '0;
      cnt_nxt   = (ent && cnt != CAP) ? cnt + CNT_W'(1) : (ext && cnt != '0) ? cnt - CNT_W'(1) : cnt;
      state_nxt = (cnt_nxt == '0) ? EMPTY : (cnt_nxt == CAP) ? FULL : AVAIL;
   end
   always_comb begin
      count    = cnt;
      empty    = state == EMPTY;
      full     = state == FULL;
      led_full = led;
   end
endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb_parking_occupancy_ctrl: directed and randomized checks against an occupancy reference model
module tb_parking_occupancy_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, s = 1'b0, r = 1'b0, err_clr = 1'b0;
   logic [2:0] count;
   logic empty, full, err_over, err_under, led_full;
   int errors = 0, checks = 0;
   int m_cnt, m_k;
   bit m_over, m_under, m_led, ps, pr;
   logic [7:0] obs;
   localparam logic [7:0] RST_VEC = 8'b000_1_0_0_0_0;

   always #5 clk = ~clk;
   assign obs = {count, empty, full, err_over, err_under, led_full};

   parking_occupancy_ctrl #(.CAPACITY(7), .CNT_W(3), .BLINK_TICKS(4)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .err_clr(err_clr),
      .count(count), .empty(empty), .full(full),
      .err_over(err_over), .err_under(err_under), .led_full(led_full)
   );

   function automatic logic [7:0] exp_vec();
      return {3'(m_cnt), m_cnt == 0, m_cnt == 7, m_over, m_under, m_led};
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_k = 0; m_over = 0; m_under = 0; m_led = 0; ps = 1; pr = 1;
   endtask

   // occupancy rules: rises only, cancel on coincidence, saturate with sticky errors,
   // led on for 4 edges then off for 4 measured from the edge that reached full
   task automatic model_step(input bit si, input bit ri, input bit ci);
      bit rs, rr, was_full;
      rs = si && !ps; rr = ri && !pr; ps = si; pr = ri;
      was_full = (m_cnt == 7);
      if (ci) begin m_over = 0; m_under = 0; end
      if (rs && !rr) begin if (m_cnt == 7) m_over = 1; else m_cnt++; end
      if (rr && !rs) begin if (m_cnt == 0) m_under = 1; else m_cnt--; end
      m_k = (m_cnt == 7 && was_full) ? m_k + 1 : 0;
      m_led = (m_cnt == 7) && ((m_k / 4) % 2 == 0);
   endtask

   task automatic cyc(input bit si, input bit ri, input bit ci);
      s = si; r = ri; err_clr = ci;
      @(posedge clk);
      model_step(si, ri, ci);
      #1;
   endtask

   task automatic pulse(input bit si, input bit ri);
      cyc(si, ri, 0);
      cyc(0, 0, 0);
   endtask

   task automatic do_reset(input bit si);
      s = si; r = 0; err_clr = 0; rst_n = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;
      cyc(si, 0, 0);
   endtask

   task automatic test_reset();
      #3 rst_n = 0;
      #1 checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL reset_vec: got %b want %b", obs, RST_VEC); end
      do_reset(0);
      checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL reset_release: got %b want %b", obs, RST_VEC); end
   endtask

   task automatic test_pulses();
      do_reset(0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1, 0, 0);
         checks++;
         if (count !== 3'(i) || empty !== 1'b0) begin errors++; $display("FAIL pulse_%0d: count=%0d empty=%b want count=%0d empty=0", i, count, empty, i); end
         cyc(0, 0, 0);
      end
   endtask

   task automatic test_hold();
      do_reset(0);
      repeat (10) cyc(1, 0, 0);
      checks++;
      if (count !== 3'd1) begin errors++; $display("FAIL hold_level: count=%0d want 1", count); end
      cyc(0, 0, 0);
      do_reset(1);
      repeat (3) cyc(1, 0, 0);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL hold_through_reset: count=%0d empty=%b want 0 1", count, empty); end
      cyc(0, 0, 0);
   endtask

   task automatic test_full_over();
      do_reset(0);
      repeat (7) pulse(1, 0);
      checks++;
      if (count !== 3'd7 || full !== 1'b1 || err_over !== 1'b0) begin errors++; $display("FAIL fill_7: count=%0d full=%b over=%b want 7 1 0", count, full, err_over); end
      cyc(1, 0, 0);
      checks++;
      if (count !== 3'd7 || full !== 1'b1 || err_over !== 1'b1) begin errors++; $display("FAIL overflow: count=%0d full=%b over=%b want 7 1 1", count, full, err_over); end
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      checks++;
      if (count !== 3'd7 || err_over !== 1'b0) begin errors++; $display("FAIL err_clr_over: count=%0d over=%b want 7 0", count, err_over); end
   endtask

   task automatic test_blink();
      do_reset(0);
      repeat (6) pulse(1, 0);
      cyc(1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (led_full !== 1'(((i / 4) % 2) == 0)) begin errors++; $display("FAIL blink_%0d: led=%b want %b", i, led_full, ((i / 4) % 2) == 0); end
         cyc(0, 0, 0);
      end
      checks++;
      if (led_full !== 1'b1) begin errors++; $display("FAIL blink_pre_exit: led=%b want 1", led_full); end
      cyc(0, 1, 0);
      checks++;
      if (count !== 3'd6 || full !== 1'b0 || led_full !== 1'b0) begin errors++; $display("FAIL leave_full: count=%0d full=%b led=%b want 6 0 0", count, full, led_full); end
      cyc(0, 0, 0);
   endtask

   task automatic test_under_simul();
      do_reset(0);
      cyc(0, 1, 0);
      checks++;
      if (count !== 3'd0 || err_under !== 1'b1) begin errors++; $display("FAIL underflow: count=%0d under=%b want 0 1", count, err_under); end
      cyc(0, 0, 1);
      checks++;
      if (err_under !== 1'b0) begin errors++; $display("FAIL err_clr_under: under=%b want 0", err_under); end
      cyc(1, 1, 0);
      checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL simul_at_0: got %b want %b", obs, RST_VEC); end
      cyc(0, 0, 0);
      repeat (7) pulse(1, 0);
      cyc(1, 1, 0);
      checks++;
      if (count !== 3'd7 || err_over !== 1'b0 || err_under !== 1'b0) begin errors++; $display("FAIL simul_at_7: count=%0d over=%b under=%b want 7 0 0", count, err_over, err_under); end
      cyc(0, 0, 0);
      cyc(1, 0, 1);
      checks++;
      if (err_over !== 1'b1) begin errors++; $display("FAIL clr_vs_new_error: over=%b want 1", err_over); end
      cyc(0, 0, 1);
   endtask

   task automatic test_async_reset();
      do_reset(0);
      repeat (5) pulse(1, 0);
      checks++;
      if (count !== 3'd5) begin errors++; $display("FAIL reach_5: count=%0d want 5", count); end
      s = 1; #2 rst_n = 0;
      model_reset();
      #1 checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL async_at_5: got %b want %b", obs, RST_VEC); end
      @(posedge clk); #1;
      checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL pending_discarded: got %b want %b", obs, RST_VEC); end
      s = 0; rst_n = 1;
      cyc(0, 0, 0);
      repeat (7) pulse(1, 0);
      checks++;
      if (led_full !== 1'b1) begin errors++; $display("FAIL led_before_reset: led=%b want 1", led_full); end
      #2 rst_n = 0;
      model_reset();
      #1 checks++;
      if (obs !== RST_VEC) begin errors++; $display("FAIL async_at_full: got %b want %b", obs, RST_VEC); end
      @(posedge clk); #1;
      rst_n = 1;
      cyc(0, 0, 0);
   endtask

   task automatic test_random();
      do_reset(0);
      for (int i = 0; i < 600; i++) begin
         bit si, ri;
         // alternate bias so the walk reaches both ends of the range
         si = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         ri = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cyc(si, ri, $urandom_range(0, 15) == 0);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL random_%0d: got %b want %b", i, obs, exp_vec()); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pulses();
      test_hold();
      test_full_over();
      test_blink();
      test_under_simul();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
